load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_we (input, 1, store when high), req_fun3 (input, 3, RISC-V size/sign code), req_addr (input, ADDR_W, byte address) and req_wdata (input, XLEN, store data, right-aligned).
REQ-006 SHALL have ports mem_valid (output, 1), mem_ready (input, 1), mem_we (output, 1), mem_addr (output, ADDR_W, word-aligned), mem_wdata (output, XLEN, lane-positioned), mem_strb (output, XLEN/8, byte enables), mem_rvalid (input, 1) and mem_rdata (input, XLEN).
REQ-007 SHALL have ports resp_valid (output, 1), resp_rdata (output, XLEN, extended load result) and resp_fault (output, 1).

Function
REQ-008 SHALL implement states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high, and all request fields are registered at acceptance.
REQ-010 SHALL decode req_fun3 as follows: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW; when XLEN=64, also 011 LD/SD and 110 LWU; any other code is a fault.
REQ-011 SHALL drive mem_valid high in REQ0/REQ1 and hold mem_addr, mem_we, mem_wdata and mem_strb stable until mem_ready is high; mem_valid never drops before acceptance.
REQ-012 Load: after acceptance in REQn, the FSM SHALL wait in WAITn for mem_rvalid and capture mem_rdata; store: acceptance in REQn completes the access, with no WAIT state.
REQ-013 An access SHALL be split when its last byte crosses an XLEN/8-byte boundary: the first access uses the lower word with upper lanes, the second uses word+XLEN/8 with lower lanes.
REQ-014 A non-split access SHALL go from REQ0/WAIT0 directly to RESP.
REQ-015 resp_valid SHALL be high for exactly one cycle in RESP, then the FSM returns to IDLE; resp_rdata is 0 for stores and faults.
REQ-016 Loads SHALL sign-extend for LB/LH/LW (XLEN=64) and zero-extend for LBU/LHU/LWU.
REQ-017 Minimum latency with mem_ready=1 and mem_rvalid one cycle after acceptance: aligned load, accept at cycle 0, resp_valid at cycle 3; aligned store, resp_valid at cycle 2.
REQ-018 Fault (illegal fun3, or misaligned without the macro) SHALL issue no memory access and SHALL go IDLE->RESP with resp_fault=1 (resp_valid at cycle 1).
REQ-019 mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.

Reset
REQ-020 While rst=0: state=IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_strb=0, resp_valid=0, resp_fault=0, and all data/address outputs = 0.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately (asynchronously), with no response issued.

Configuration
REQ-022 Macro LSU_MISALIGN_EN defined: the FSM performs split accesses per REQ-013. Undefined: any access not naturally aligned to its size faults per REQ-018, and states REQ1/WAIT1 are not built.

Structure
REQ-023 Package lsu_pkg SHALL hold the state enum, the fun3 code constants and a size-decode function.
REQ-024 Sub-module lsu_align SHALL be purely combinational, performing lane shift, strobe generation and load merge/extension; the FSM stays in load_store_unit.

Verification (XLEN=32)
REQ-025 Reset: hold rst=0 for 2 cycles, then release -> req_ready=1, mem_valid=0, resp_valid=0.
REQ-026 LW at 0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_strb=1111, resp_valid at cycle 3, resp_rdata=0xDEADBEEF.
REQ-027 Word 0x80FF0000 at 0x100: LB at 0x103 -> 0xFFFFFF80; LBU at 0x103 -> 0x00000080; SH at 0x102 with data 0xABCD -> mem_wdata=0xABCD0000, mem_strb=1100.
REQ-028 With macro: LW at 0x101, words 0x44332211 and 0x88776655 -> reads from 0x100 then 0x104, resp_rdata=0x55443322; SW at 0x101 with data 0x55443322 -> (0x100, strb 1110, 0x44332200) then (0x104, strb 0001, 0x00000055). Without macro -> resp_fault=1 at cycle 1, no mem_valid.
REQ-029 mem_ready held low for 3 cycles -> mem_valid and mem_addr stable throughout; rst pulsed in WAIT0 -> IDLE, no resp_valid, a later stray mem_rvalid is ignored.
REQ-030 Illegal fun3 011 with XLEN=32 -> resp_fault=1, resp_rdata=0, no memory access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V fun3 size codes
// and the fun3 decoder used at request acceptance.
package lsu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq0,
      StWait0,
      StReq1,
      StWait1,
      StResp
   } lsu_state_e;

   localparam logic [2:0] Fun3B  = 3'b000;
   localparam logic [2:0] Fun3H  = 3'b001;
   localparam logic [2:0] Fun3W  = 3'b010;
   localparam logic [2:0] Fun3D  = 3'b011;
   localparam logic [2:0] Fun3Bu = 3'b100;
   localparam logic [2:0] Fun3Hu = 3'b101;
   localparam logic [2:0] Fun3Wu = 3'b110;

   // size is log2 of the access width in bytes
   typedef struct packed {
      logic       legal;
      logic       sign;
      logic [1:0] size;
   } fun3_dec_t;

   function automatic fun3_dec_t decode_fun3(input logic [2:0] fun3, input logic store,
                                             input logic wide);
      fun3_dec_t d;
      d = '{legal: 1'b0, sign: 1'b0, size: 2'd0};
      case (fun3)
         Fun3B:   d = '{legal: 1'b1,          sign: 1'b1, size: 2'd0};
         Fun3H:   d = '{legal: 1'b1,          sign: 1'b1, size: 2'd1};
         Fun3W:   d = '{legal: 1'b1,          sign: 1'b1, size: 2'd2};
         Fun3D:   d = '{legal: wide,          sign: 1'b1, size: 2'd3};
         Fun3Bu:  d = '{legal: !store,        sign: 1'b0, size: 2'd0};
         Fun3Hu:  d = '{legal: !store,        sign: 1'b0, size: 2'd1};
         Fun3Wu:  d = '{legal: wide && !store, sign: 1'b0, size: 2'd2};
         default: d = '{legal: 1'b0,          sign: 1'b0, size: 2'd0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: positions store data and byte enables for either
// half of a (possibly split) access and merges/extends load data.
module lsu_align #(
   parameter int unsigned XLEN = 32
) (
   input  logic [$clog2(XLEN/8)-1:0] offset,
   input  logic [1:0]                size,
   input  logic                      sign,
   input  logic                      part,
   input  logic [XLEN-1:0]           wdata,
   input  logic [XLEN-1:0]           rdata_lo,
   input  logic [XLEN-1:0]           rdata_hi,
   output logic [XLEN-1:0]           lane_wdata,
   output logic [XLEN/8-1:0]         lane_strb,
   output logic [XLEN-1:0]           load_data
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned LW = $clog2(XLEN);

   logic [XLEN-1:0]   size_mask;
   logic [XLEN-1:0]   raw;
   logic [NB-1:0]     byte_mask;
   logic [2*XLEN-1:0] wide_w;
   logic [2*NB-1:0]   wide_s;
   logic [LW-1:0]     msb;

   // Work on a double-width window: the low half is the first word of a split
   // access, the high half the second.
   always_comb begin
      size_mask  = ~({XLEN{1'b1}} << (32'd8 << size));
      byte_mask  = ~({NB{1'b1}} << (32'd1 << size));
      wide_w     = {{XLEN{1'b0}}, wdata & size_mask} << {offset, 3'b000};
      wide_s     = {{NB{1'b0}}, byte_mask} << offset;
      lane_wdata = part ? wide_w[2*XLEN-1:XLEN] : wide_w[XLEN-1:0];
      lane_strb  = part ? wide_s[2*NB-1:NB] : wide_s[NB-1:0];
      raw        = XLEN'({rdata_hi, rdata_lo} >> {offset, 3'b000});
      msb        = LW'((32'd8 << size) - 32'd1);
      load_data  = (raw & size_mask) | (~size_mask & {XLEN{sign & raw[msb]}});
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM. Define LSU_MISALIGN_EN to split accesses that cross a
// word boundary; otherwise misaligned accesses fault.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_fun3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_strb,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);

   lsu_state_e        state_q, state_d;
   fun3_dec_t         dec;
   logic              we_q, sign_q, fault_q, fault_d, more, part, in_req;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q, word_addr;
   logic [XLEN-1:0]   wdata_q, rdata0_q, rdata_hi, lane_wdata, load_data;
   logic [NB-1:0]     lane_strb;

   assign dec = decode_fun3(req_fun3, req_we, XLEN == 64);

`ifdef LSU_MISALIGN_EN
   logic            split_q, split_d;
   logic [XLEN-1:0] rdata1_q;

   always_comb begin
      fault_d = !dec.legal;
      split_d = (32'(req_addr[OW-1:0]) + (32'd1 << dec.size)) > NB;
   end
   assign more     = split_q && (state_q == StReq0 || state_q == StWait0);
   assign rdata_hi = rdata1_q;
`else
   always_comb begin
      fault_d = !dec.legal || ((req_addr[OW-1:0] & OW'((32'd1 << dec.size) - 32'd1)) != '0);
   end
   assign more     = 1'b0;
   assign rdata_hi = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         sign_q   <= 1'b0;
         fault_q  <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
`ifdef LSU_MISALIGN_EN
         split_q  <= 1'b0;
         rdata1_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && req_valid) begin
            we_q    <= req_we;
            sign_q  <= dec.sign;
            fault_q <= fault_d;
            size_q  <= dec.size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef LSU_MISALIGN_EN
            split_q <= split_d;
`endif
         end
         if (state_q == StWait0 && mem_rvalid) rdata0_q <= mem_rdata;
`ifdef LSU_MISALIGN_EN
         if (state_q == StWait1 && mem_rvalid) rdata1_q <= mem_rdata;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (req_valid) state_d = fault_d ? StResp : StReq0;
         StReq0:  if (mem_ready) state_d = we_q ? (more ? StReq1 : StResp) : StWait0;
         StWait0: if (mem_rvalid) state_d = more ? StReq1 : StResp;
`ifdef LSU_MISALIGN_EN
         StReq1:  if (mem_ready) state_d = we_q ? StResp : StWait1;
         StWait1: if (mem_rvalid) state_d = StResp;
`endif
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .offset    (addr_q[OW-1:0]),
      .size      (size_q),
      .sign      (sign_q),
      .part      (part),
      .wdata     (wdata_q),
      .rdata_lo  (rdata0_q),
      .rdata_hi  (rdata_hi),
      .lane_wdata(lane_wdata),
      .lane_strb (lane_strb),
      .load_data (load_data)
   );

   assign part      = (state_q == StReq1);
   assign in_req    = (state_q == StReq0) || part;
   assign word_addr = {addr_q[ADDR_W-1:OW], {OW{1'b0}}} + (part ? ADDR_W'(NB) : '0);

   assign req_ready  = (state_q == StIdle);
   assign mem_valid  = in_req;
   assign mem_we     = in_req && we_q;
   assign mem_addr   = in_req ? word_addr : '0;
   assign mem_wdata  = (in_req && we_q) ? lane_wdata : '0;
   assign mem_strb   = in_req ? lane_strb : '0;
   assign resp_valid = (state_q == StResp);
   assign resp_fault = resp_valid && fault_q;
   assign resp_rdata = (resp_valid && !we_q && !fault_q) ? load_data : '0;

endmodule
